// File: rtl/sdram32_device_model_if.sv
// SDRAM command/address bus between controller (master) and device model (slave).
// Latency: none; plain wires.
// Backpressure: none; the SDRAM bus has no flow control. dq_oe reports which data lanes the device drives.
interface sdram32_device_model_if;
    logic        sd_cke;
    logic [10:0] sd_addr;
    logic [3:0]  sd_dqm;
    logic [1:0]  sd_ba;
    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [3:0]  dq_oe;

    modport master (
        output sd_cke, sd_addr, sd_dqm, sd_ba, sd_cs, sd_ras, sd_cas, sd_we,
        input  dq_oe
    );

    modport slave (
        input  sd_cke, sd_addr, sd_dqm, sd_ba, sd_cs, sd_ras, sd_cas, sd_we,
        output dq_oe
    );
endinterface

// File: rtl/sdram32_device_model.sv
// Cycle-level model of a 4-bank 32-bit SDR SDRAM: command decode, open-row tracking, storage, protocol checks.
// Latency: read data valid CL (2 or 3) edges after READ; errors reported the edge after detection.
// Backpressure: none; clock suspend (cke=0) freezes all state. Optional refresh check: SDRAM_REFRESH_CHECK_EN.
module sdram32_device_model #(
    parameter int MEM_AW  = 21,
    parameter int TRCD    = 2,
    parameter int REF_MAX = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sdram32_device_model_if.slave bus,
    inout  wire  [31:0]           sd_data,
    output logic                  mode_ok,
    output logic                  proto_err,
    output logic [2:0]            err_code,
    output logic [7:0]            err_count
);

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_BT  = 3'b110;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    localparam int RCD_W = $clog2(TRCD + 2);
    localparam logic [RCD_W-1:0] RCD_SAT = RCD_W'(TRCD);
    // rcd is cleared at the ACTIVE edge and advanced after each later edge, so at a
    // command edge it holds (edges since ACTIVE - 1).
    localparam logic [RCD_W-1:0] RCD_NEED = RCD_W'(TRCD - 1);

    if (TRCD < 1 || REF_MAX < 2 || MEM_AW < 1 || MEM_AW > 21) begin : g_bad_param
        $error("sdram32_device_model: parameter out of range");
    end

    // Command decode
    logic       cmd_vld;
    logic [2:0] cmd;
    logic       is_act, is_rd, is_wr, is_bt, is_pre, is_ref, is_lmr;

    assign cmd_vld = ~bus.sd_cs & bus.sd_cke;
    assign cmd     = {bus.sd_ras, bus.sd_cas, bus.sd_we};
    assign is_act  = cmd_vld && (cmd == CMD_ACT);
    assign is_rd   = cmd_vld && (cmd == CMD_RD);
    assign is_wr   = cmd_vld && (cmd == CMD_WR);
    assign is_bt   = cmd_vld && (cmd == CMD_BT);
    assign is_pre  = cmd_vld && (cmd == CMD_PRE);
    assign is_ref  = cmd_vld && (cmd == CMD_REF);
    assign is_lmr  = cmd_vld && (cmd == CMD_LMR);

    // Bank state
    logic [3:0]       open_q;
    logic [3:0]       ap_pend;
    logic [10:0]      row_q [4];
    logic [RCD_W-1:0] rcd_q [4];

    logic cur_open, cur_rcd_ok, any_open, mode_legal;
    assign cur_open   = open_q[bus.sd_ba];
    assign cur_rcd_ok = rcd_q[bus.sd_ba] >= RCD_NEED;
    assign any_open   = |open_q;
    // BL=1, CL 2 or 3, A10/A8/A7 zero; A3 and A9 are don't-care
    assign mode_legal = (bus.sd_addr[2:0] == 3'b000) &&
                        ((bus.sd_addr[6:4] == 3'd2) || (bus.sd_addr[6:4] == 3'd3)) &&
                        !bus.sd_addr[10] && (bus.sd_addr[8:7] == 2'b00);

    logic rw_ok, rd_ok, wr_ok, lmr_ok, cancel, ref_due;
    assign rw_ok  = (is_rd | is_wr) && mode_ok && cur_open && cur_rcd_ok;
    assign rd_ok  = rw_ok & is_rd;
    assign wr_ok  = rw_ok & is_wr;
    assign lmr_ok = is_lmr && !any_open && mode_legal;
    assign cancel = is_bt | is_wr;

    // Refresh watchdog: armed on the first accepted mode load
`ifdef SDRAM_REFRESH_CHECK_EN
    localparam int REF_W = $clog2(REF_MAX + 1);
    logic             ref_run;
    logic [REF_W-1:0] ref_cnt;

    assign ref_due = ref_run && !is_ref && (ref_cnt == REF_W'(REF_MAX - 1));

    // Count active edges since the last AUTO_REFRESH; restart after flagging overdue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_run <= 1'b0;
            ref_cnt <= '0;
        end else if (bus.sd_cke) begin
            if (lmr_ok && !mode_ok) begin
                ref_run <= 1'b1;
                ref_cnt <= '0;
            end else if (ref_run) begin
                if (is_ref || ref_due) ref_cnt <= '0;
                else                   ref_cnt <= ref_cnt + REF_W'(1);
            end
        end
    end
`else
    assign ref_due = 1'b0;
`endif

    // Violation classification; lowest code wins
    logic [2:0] err_det;
    always_comb begin
        err_det = 3'd0;
        if ((is_rd | is_wr) && !mode_ok)            err_det = 3'd1;
        else if ((is_rd | is_wr) && !cur_open)      err_det = 3'd2;
        else if ((is_rd | is_wr) && !cur_rcd_ok)    err_det = 3'd3;
        else if (is_act && cur_open)                err_det = 3'd4;
        else if ((is_ref | is_lmr) && any_open)     err_det = 3'd5;
        else if (is_lmr && !mode_legal)             err_det = 3'd6;
        else if (ref_due)                           err_det = 3'd7;
    end

    // Backing store, indexed by {ba,row,col}; not cleared by reset
    logic [31:0]       mem [0:(1 << MEM_AW) - 1];
    logic [20:0]       word_addr;
    logic [MEM_AW-1:0] mem_idx;
    logic [31:0]       rd_word;

    assign word_addr = {bus.sd_ba, row_q[bus.sd_ba], bus.sd_addr[7:0]};
    assign mem_idx   = word_addr[MEM_AW-1:0];
    assign rd_word   = mem[mem_idx];

    // Byte-masked write at the WRITE command edge
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.sd_dqm[i]) mem[mem_idx][8*i +: 8] <= sd_data[8*i +: 8];
            end
        end
    end

    // Per-bank open/row/tRCD tracking and auto-precharge close one edge after the access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q  <= '0;
            ap_pend <= '0;
            for (int b = 0; b < 4; b++) begin
                row_q[b] <= '0;
                rcd_q[b] <= '0;
            end
        end else if (bus.sd_cke) begin
            for (int b = 0; b < 4; b++) begin
                if (rcd_q[b] != RCD_SAT) rcd_q[b] <= rcd_q[b] + RCD_W'(1);
                if (ap_pend[b]) begin
                    open_q[b]  <= 1'b0;
                    ap_pend[b] <= 1'b0;
                end
                if (is_act && (bus.sd_ba == 2'(b))) begin
                    open_q[b] <= 1'b1;
                    row_q[b]  <= bus.sd_addr;
                    rcd_q[b]  <= '0;
                end
                if (is_pre && (bus.sd_addr[10] || (bus.sd_ba == 2'(b)))) begin
                    open_q[b]  <= 1'b0;
                    ap_pend[b] <= 1'b0;
                end
                if (rw_ok && bus.sd_addr[10] && (bus.sd_ba == 2'(b))) ap_pend[b] <= 1'b1;
            end
        end
    end

    // Mode register: CL latched only from a legal LOAD_MODE
    logic cl3;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_ok <= 1'b0;
            cl3     <= 1'b0;
        end else if (lmr_ok) begin
            mode_ok <= 1'b1;
            cl3     <= bus.sd_addr[4];
        end
    end

    // Read pipeline: p2 (CL=3 only) -> p1 -> bus. Lane enables come from dqm at the
    // edge a word enters p1, which is edge T+CL-2.
    logic        p2_vld, p1_vld;
    logic [31:0] p2_dat, p1_dat, dq_dat;
    logic [3:0]  p1_lane, dq_oe;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p2_vld  <= 1'b0;
            p2_dat  <= '0;
            p1_vld  <= 1'b0;
            p1_dat  <= '0;
            p1_lane <= '0;
            dq_oe   <= '0;
            dq_dat  <= '0;
        end else if (bus.sd_cke) begin
            if (cancel) begin
                p2_vld <= 1'b0;
                p1_vld <= 1'b0;
                dq_oe  <= '0;
            end else begin
                dq_oe  <= p1_vld ? p1_lane : 4'b0000;
                dq_dat <= p1_dat;
                if (rd_ok && !cl3) begin
                    p1_vld  <= 1'b1;
                    p1_dat  <= rd_word;
                    p1_lane <= ~bus.sd_dqm;
                end else if (p2_vld) begin
                    p1_vld  <= 1'b1;
                    p1_dat  <= p2_dat;
                    p1_lane <= ~bus.sd_dqm;
                end else begin
                    p1_vld  <= 1'b0;
                end
                p2_vld <= rd_ok && cl3;
                if (rd_ok && cl3) p2_dat <= rd_word;
            end
        end
    end

    assign bus.dq_oe = dq_oe;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign sd_data[8*i +: 8] = dq_oe[i] ? dq_dat[8*i +: 8] : 8'hzz;
    end

    // Error reporting: one-cycle pulse, sticky code, saturating count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
            err_code  <= 3'd0;
            err_count <= 8'd0;
        end else begin
            proto_err <= bus.sd_cke && (err_det != 3'd0);
            if (bus.sd_cke && (err_det != 3'd0)) begin
                err_code <= err_det;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram32_device_model.sv
// Directed bench for sdram32_device_model: table of per-edge commands with expected status/data.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_sdram32_device_model;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] BT  = 3'b110;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] LMR = 3'b000;

    typedef struct {
        logic        cke;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [10:0] addr;
        logic [3:0]  dqm;
        logic [31:0] wdat;
        logic        mok;
        logic        pe;
        logic [2:0]  code;
        logic [7:0]  cnt;
        logic [3:0]  oe;
        logic [31:0] rdat;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        mode_ok;
    logic        proto_err;
    logic [2:0]  err_code;
    logic [7:0]  err_count;
    wire  [31:0] sd_data;
    logic        tb_oe;
    logic [31:0] tb_dat;
    int          checks;
    int          errors;
    vec_t        tbl[$];

    sdram32_device_model_if bus();

    assign sd_data = tb_oe ? tb_dat : 32'hzzzz_zzzz;

    sdram32_device_model dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .sd_data   (sd_data),
        .mode_ok   (mode_ok),
        .proto_err (proto_err),
        .err_code  (err_code),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic cke, input logic [2:0] cmd, input logic [1:0] ba,
                                input logic [10:0] addr, input logic [3:0] dqm, input logic [31:0] wdat,
                                input logic mok, input logic pe, input logic [2:0] code,
                                input logic [7:0] cnt, input logic [3:0] oe, input logic [31:0] rdat);
        vec_t v;
        v.cke = cke; v.cmd = cmd; v.ba = ba; v.addr = addr; v.dqm = dqm; v.wdat = wdat;
        v.mok = mok; v.pe = pe; v.code = code; v.cnt = cnt; v.oe = oe; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_status(input int idx, input logic mok, input logic pe, input logic [2:0] code,
                              input logic [7:0] cnt, input logic [3:0] oe, input logic [31:0] rdat);
        logic [31:0] mask;
        mask = {{8{oe[3]}}, {8{oe[2]}}, {8{oe[1]}}, {8{oe[0]}}};
        chk("mode_ok",   idx, 32'(mode_ok),   32'(mok));
        chk("proto_err", idx, 32'(proto_err), 32'(pe));
        chk("err_code",  idx, 32'(err_code),  32'(code));
        chk("err_count", idx, 32'(err_count), 32'(cnt));
        chk("dq_oe",     idx, 32'(bus.dq_oe), 32'(oe));
        if (oe != 4'b0000) chk("rdata", idx, sd_data & mask, rdat & mask);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        bus.sd_cke = v.cke;
        bus.sd_cs  = 1'b0;
        {bus.sd_ras, bus.sd_cas, bus.sd_we} = v.cmd;
        bus.sd_ba   = v.ba;
        bus.sd_addr = v.addr;
        bus.sd_dqm  = v.dqm;
        tb_oe  = (v.cmd == WR);
        tb_dat = v.wdat;
        @(posedge clk);
        #1;
        chk_status(idx, v.mok, v.pe, v.code, v.cnt, v.oe, v.rdat);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        tb_oe = 1'b0;
        tb_dat = '0;
        bus.sd_cke = 1'b1;
        bus.sd_cs = 1'b1;
        {bus.sd_ras, bus.sd_cas, bus.sd_we} = NOP;
        bus.sd_ba = '0;
        bus.sd_addr = '0;
        bus.sd_dqm = '0;

        //                cke cmd  ba  addr     dqm      wdat          mok pe code cnt oe       rdat
        tbl.push_back(mk(1, PRE, 0, 11'h400, 4'h0, 32'h0,          0, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, LMR, 0, 11'h220, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, ACT, 1, 11'h155, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, WR,  1, 11'h03C, 4'h0, 32'h11223344,   1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, WR,  1, 11'h03D, 4'h0, 32'h5A5A0F0F,   1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, WR,  1, 11'h43C, 4'h7, 32'hA1B2C3D4,   1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, ACT, 1, 11'h155, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  1, 11'h03C, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b1111, 32'hA1223344));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  1, 11'h03C, 4'hA, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0101, 32'hA1223344));
        tbl.push_back(mk(1, RD,  1, 11'h03C, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  1, 11'h03D, 4'h0, 32'h0,          1, 0, 0, 0, 4'b1111, 32'hA1223344));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b1111, 32'h5A5A0F0F));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  1, 11'h03C, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, BT,  0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, PRE, 0, 11'h400, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, LMR, 0, 11'h230, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, ACT, 1, 11'h155, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  1, 11'h03C, 4'hF, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h1, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b1110, 32'hA1223344));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, PRE, 0, 11'h400, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, ACT, 0, 11'h010, 4'h0, 32'h0,          1, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  0, 11'h005, 4'h0, 32'h0,          1, 1, 3, 1, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 3, 1, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 3, 1, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 3, 1, 4'b0000, 32'h0));
        tbl.push_back(mk(1, RD,  2, 11'h000, 4'h0, 32'h0,          1, 1, 2, 2, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 2, 2, 4'b0000, 32'h0));
        tbl.push_back(mk(1, PRE, 0, 11'h400, 4'h0, 32'h0,          1, 0, 2, 2, 4'b0000, 32'h0));
        tbl.push_back(mk(1, LMR, 0, 11'h221, 4'h0, 32'h0,          1, 1, 6, 3, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 6, 3, 4'b0000, 32'h0));
        tbl.push_back(mk(1, ACT, 0, 11'h010, 4'h0, 32'h0,          1, 0, 6, 3, 4'b0000, 32'h0));
        tbl.push_back(mk(1, ACT, 0, 11'h011, 4'h0, 32'h0,          1, 1, 4, 4, 4'b0000, 32'h0));
        tbl.push_back(mk(1, REF, 0, 11'h000, 4'h0, 32'h0,          1, 1, 5, 5, 4'b0000, 32'h0));
        tbl.push_back(mk(1, PRE, 0, 11'h000, 4'h0, 32'h0,          1, 0, 5, 5, 4'b0000, 32'h0));
        tbl.push_back(mk(1, REF, 0, 11'h000, 4'h0, 32'h0,          1, 0, 5, 5, 4'b0000, 32'h0));
        tbl.push_back(mk(0, RD,  0, 11'h03C, 4'h0, 32'h0,          1, 0, 5, 5, 4'b0000, 32'h0));
        tbl.push_back(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0,          1, 0, 5, 5, 4'b0000, 32'h0));
        tbl.push_back(mk(1, LMR, 0, 11'h240, 4'h0, 32'h0,          1, 1, 6, 6, 4'b0000, 32'h0));

        // Reset state
        #12;
        chk_status(-1, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Reset while read data is on the bus (CL=2)
        apply(mk(1, PRE, 0, 11'h400, 4'h0, 32'h0, 1, 0, 6, 6, 4'b0000, 32'h0), 100);
        apply(mk(1, LMR, 0, 11'h220, 4'h0, 32'h0, 1, 0, 6, 6, 4'b0000, 32'h0), 101);
        apply(mk(1, ACT, 1, 11'h155, 4'h0, 32'h0, 1, 0, 6, 6, 4'b0000, 32'h0), 102);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 1, 0, 6, 6, 4'b0000, 32'h0), 103);
        apply(mk(1, RD,  1, 11'h03C, 4'h0, 32'h0, 1, 0, 6, 6, 4'b0000, 32'h0), 104);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 1, 0, 6, 6, 4'b1111, 32'hA1223344), 105);
        reset_n = 1'b0;
        #1;
        chk_status(106, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 32'h0);
        @(posedge clk);
        #1;
        chk_status(107, 1'b0, 1'b0, 3'd0, 8'd0, 4'b0000, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // After reset: access before mode load, then array contents survive reset
        apply(mk(1, ACT, 1, 11'h155, 4'h0, 32'h0, 0, 0, 0, 0, 4'b0000, 32'h0), 110);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 0, 0, 0, 0, 4'b0000, 32'h0), 111);
        apply(mk(1, RD,  1, 11'h03C, 4'h0, 32'h0, 0, 1, 1, 1, 4'b0000, 32'h0), 112);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 0, 0, 1, 1, 4'b0000, 32'h0), 113);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 0, 0, 1, 1, 4'b0000, 32'h0), 114);
        apply(mk(1, PRE, 0, 11'h400, 4'h0, 32'h0, 0, 0, 1, 1, 4'b0000, 32'h0), 115);
        apply(mk(1, LMR, 0, 11'h220, 4'h0, 32'h0, 1, 0, 1, 1, 4'b0000, 32'h0), 116);
        apply(mk(1, ACT, 1, 11'h155, 4'h0, 32'h0, 1, 0, 1, 1, 4'b0000, 32'h0), 117);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 1, 0, 1, 1, 4'b0000, 32'h0), 118);
        apply(mk(1, RD,  1, 11'h03D, 4'h0, 32'h0, 1, 0, 1, 1, 4'b0000, 32'h0), 119);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 1, 0, 1, 1, 4'b1111, 32'h5A5A0F0F), 120);
        apply(mk(1, NOP, 0, 11'h000, 4'h0, 32'h0, 1, 0, 1, 1, 4'b0000, 32'h0), 121);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
